matrix_scan: RTL and testbench

Row-multiplexing driver for the 8x16 LED matrix; it sits directly downstream of the snake pixel generator. It consumes the 128-bit frame image and produces `MATRIX_ROW`/`MATRIX_COL`. It latches the frame only at frame boundaries, so the displayed image never tears. It inserts a blanking gap between rows to suppress ghosting and flags each new frame.

---
 rtl/matrix_scan.sv | 131 +++++++++++++
 tb/tb_matrix_scan.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/matrix_scan.sv
// Row-multiplexing scan driver for the 8x16 LED matrix with tear-free frame latching and inter-row blanking.
// Optional feature: define MATRIX_SCAN_DIM_EN to add the 2-bit brightness input (per-row column duty gating).
module matrix_scan #(
    parameter int DWELL = 1024,
    parameter int BLANK = 16
) (
    input  logic         clk,
    input  logic         reset,
`ifdef MATRIX_SCAN_DIM_EN
    input  logic [1:0]   brightness,
`endif
    input  logic [127:0] pixelReg,
    output logic [7:0]   MATRIX_ROW,
    output logic [15:0]  MATRIX_COL,
    output logic         frame_start
);

    localparam int MAX_COUNT = (DWELL > BLANK) ? DWELL : BLANK;
    localparam int CW        = $clog2(MAX_COUNT);

    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK - 1);
    localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL - 1);

    typedef enum logic {
        S_BLANK,
        S_SHOW
    } scanState_t;

    // The state/counter/row registers describe the phase the outputs will
    // present after the next edge; the output registers trail them by one.
    scanState_t     state, nextState;
    logic [CW-1:0]  cnt, nextCnt;
    logic [2:0]     row, nextRow;
    logic [127:0]   frameBuf;

    logic showFirst;
    logic latchNow;
    logic colEnable;

    assign showFirst = (state == S_SHOW) && (cnt == '0);
    assign latchNow  = showFirst && (row == 3'd0);

`ifdef MATRIX_SCAN_DIM_EN
    localparam int QUARTER = DWELL / 4;

    logic [1:0] brightRow;

    // The first lit cycle is always inside the window, so the stale
    // brightRow value seen on that cycle is harmless.
    assign colEnable = int'(cnt) < ((int'(brightRow) + 1) * QUARTER);
`else
    assign colEnable = 1'b1;
`endif

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_BLANK;
            cnt   <= '0;
            row   <= 3'd0;
        end else begin
            state <= nextState;
            cnt   <= nextCnt;
            row   <= nextRow;
        end
    end

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        nextState = state;
        nextCnt   = cnt + 1'b1;
        nextRow   = row;
        case (state)
            S_BLANK: begin
                if (cnt == BLANK_LAST) begin
                    nextState = S_SHOW;
                    nextCnt   = '0;
                end
            end
            S_SHOW: begin
                if (cnt == DWELL_LAST) begin
                    nextState = S_BLANK;
                    nextCnt   = '0;
                    nextRow   = row + 1'b1;
                end
            end
            default: begin
                nextState = S_BLANK;
                nextCnt   = '0;
            end
        endcase
    end

    // NOTE: the frame buffer is an ordinary register bank, so it is cleared on reset to guarantee a dark start.
    always_ff @(posedge clk) begin
        if (reset) begin
            frameBuf    <= '0;
            MATRIX_ROW  <= '0;
            MATRIX_COL  <= '0;
            frame_start <= 1'b0;
`ifdef MATRIX_SCAN_DIM_EN
            brightRow   <= 2'd0;
`endif
        end else begin
            frame_start <= latchNow;
            if (latchNow) begin
                frameBuf <= pixelReg;
            end
`ifdef MATRIX_SCAN_DIM_EN
            if (showFirst) begin
                brightRow <= brightness;
            end
`endif
            if (state == S_SHOW) begin
                MATRIX_ROW <= 8'b1 << row;
                // Row 0's first lit cycle shows the image being latched on this very edge.
                if (latchNow) begin
                    MATRIX_COL <= pixelReg[15:0];
                end else if (colEnable) begin
                    MATRIX_COL <= frameBuf[{row, 4'b0000} +: 16];
                end else begin
                    MATRIX_COL <= '0;
                end
            end else begin
                MATRIX_ROW <= '0;
                MATRIX_COL <= '0;
            end
        end
    end

endmodule

// File: tb/tb_matrix_scan.sv
// Self-checking bench for matrix_scan: randomized pixel data against a cycle-count based reference model.
// Exercises the brightness gating as well when MATRIX_SCAN_DIM_EN is defined.
module tb_matrix_scan;

    localparam int DWELL  = 8;
    localparam int BLANK  = 2;
    localparam int ROWP   = DWELL + BLANK;
    localparam int FRAMEP = 8 * ROWP;

    logic         clk = 1'b0;
    logic         reset;
    logic [127:0] pixelReg;
    logic [7:0]   MATRIX_ROW;
    logic [15:0]  MATRIX_COL;
    logic         frame_start;
`ifdef MATRIX_SCAN_DIM_EN
    logic [1:0]   brightness;
`endif

    matrix_scan #(
        .DWELL(DWELL),
        .BLANK(BLANK)
    ) dut (
        .clk        (clk),
        .reset      (reset),
`ifdef MATRIX_SCAN_DIM_EN
        .brightness (brightness),
`endif
        .pixelReg   (pixelReg),
        .MATRIX_ROW (MATRIX_ROW),
        .MATRIX_COL (MATRIX_COL),
        .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: edges elapsed since reset release decide everything.
    int           k = -1;
    int           cycle = 0;
    int           lastPulse = -1;
    logic [127:0] shown = '0;
    int           bRow = 3;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s @cycle %0d: got %h expected %h", tag, cycle, got, exp);
        end
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // One clock edge with the currently driven inputs, then compare against the model.
    task automatic step();
        logic [7:0]  expRow;
        logic [15:0] expCol;
        logic        expFs;
        int          phase, r, w;
        @(posedge clk);
        cycle++;
        expRow = '0;
        expCol = '0;
        expFs  = 1'b0;
        if (reset) begin
            k         = -1;
            shown     = '0;
            lastPulse = -1;
        end else begin
            k++;
            phase = k % FRAMEP;
            r     = phase / ROWP;
            w     = phase % ROWP;
            if (phase == BLANK) begin
                shown = pixelReg;
                expFs = 1'b1;
            end
            if (w == BLANK) begin
`ifdef MATRIX_SCAN_DIM_EN
                bRow = int'(brightness);
`else
                bRow = 3;
`endif
            end
            if (w >= BLANK) begin
                expRow = 8'(1 << r);
                if ((w - BLANK) < ((bRow + 1) * DWELL / 4)) begin
                    expCol = shown[r*16 +: 16];
                end
            end
        end
        #1;
        check("row", 32'(MATRIX_ROW), 32'(expRow));
        check("col", 32'(MATRIX_COL), 32'(expCol));
        check("frame_start", 32'(frame_start), 32'(expFs));
        check("row_onehot", 32'($countones(MATRIX_ROW) > 1), 32'd0);
        if (frame_start) begin
            if (lastPulse >= 0) begin
                check("pulse_spacing", 32'(cycle - lastPulse), 32'(FRAMEP));
            end
            lastPulse = cycle;
        end
    endtask

    task automatic runSteps(input int n, input bit randomPix);
        for (int i = 0; i < n; i++) begin
            if (randomPix && ($urandom_range(0, 7) == 0)) begin
                pixelReg = rand128();
            end
`ifdef MATRIX_SCAN_DIM_EN
            if (randomPix && ($urandom_range(0, 5) == 0)) begin
                brightness = 2'($urandom_range(0, 3));
            end
`endif
            step();
        end
    endtask

    initial begin
        reset    = 1'b1;
        pixelReg = rand128();
`ifdef MATRIX_SCAN_DIM_EN
        brightness = 2'd3;
`endif

        // Reset held with arbitrary pixels: everything dark.
        for (int i = 0; i < 5; i++) begin
            pixelReg = rand128();
            step();
        end

        // Row 0 = A5A5, row 7 = 8001; release and scan into row 3 of the first frame.
        pixelReg           = rand128();
        pixelReg[15:0]     = 16'hA5A5;
        pixelReg[127:112]  = 16'h8001;
        reset              = 1'b0;
        runSteps(3 * ROWP + BLANK + 3, 1'b0);

        // Mid-frame change must not tear; it appears from the next frame_start.
        pixelReg[15:0] = 16'hFFFF;
        runSteps(2 * FRAMEP, 1'b0);

        // Randomized content and brightness changes at arbitrary times.
        runSteps(4 * FRAMEP, 1'b1);

        // Reset during row 5 lit time.
        for (int i = 0; i < FRAMEP; i++) begin
            if (((k % FRAMEP) / ROWP == 5) && ((k % ROWP) >= BLANK + 2)) break;
            step();
        end
        check("in_row5", 32'((k % FRAMEP) / ROWP), 32'd5);
        reset = 1'b1;
        step();
        reset = 1'b0;
        pixelReg = rand128();
        runSteps(2 * FRAMEP, 1'b1);

        // A few short random resets.
        for (int j = 0; j < 3; j++) begin
            reset = 1'b1;
            runSteps($urandom_range(1, 3), 1'b1);
            reset = 1'b0;
            runSteps($urandom_range(5, 2 * FRAMEP), 1'b1);
        end

`ifdef MATRIX_SCAN_DIM_EN
        // Brightness 1 on a fully lit row 0: half-duty columns.
        reset = 1'b1;
        step();
        brightness     = 2'd1;
        pixelReg       = rand128();
        pixelReg[15:0] = 16'hFFFF;
        reset          = 1'b0;
        runSteps(FRAMEP + ROWP, 1'b0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
